// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC, single-outstanding imem request, instruction register
// Optional unsupported-instruction flag is built when IF_ILLEGAL_CHECK_EN is defined.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        illegal_instr
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        valid_q;
  logic        req_q;

`ifdef IF_ILLEGAL_CHECK_EN
  logic illegal_q;

  // Only loads, stores and the add/sub/or/and register ops are supported by the core.
  function automatic logic is_unsupported(input logic [31:0] w);
    logic legal;
    legal = 1'b0;
    case (w[6:0])
      7'b0000011: legal = 1'b1;
      7'b0100011: legal = 1'b1;
      7'b0110011: begin
        if (w[14:12] == 3'b000 && (w[31:25] == 7'b0000000 || w[31:25] == 7'b0100000))
          legal = 1'b1;
        else if ((w[14:12] == 3'b110 || w[14:12] == 3'b111) && w[31:25] == 7'b0000000)
          legal = 1'b1;
        else
          legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    return !legal;
  endfunction
`endif

  // Fetch FSM: request, wait for the memory response, hold until the core accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= REQ;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      valid_q <= 1'b0;
      req_q   <= 1'b1;
`ifdef IF_ILLEGAL_CHECK_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      case (state)
        REQ: begin
          // The request is a one-cycle pulse; a response in this same cycle is ignored.
          state <= WAIT;
          req_q <= 1'b0;
        end
        WAIT: begin
          if (imem_rvalid) begin
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
            state   <= HOLD;
`ifdef IF_ILLEGAL_CHECK_EN
            illegal_q <= is_unsupported(imem_rdata);
`endif
          end
        end
        HOLD: begin
          // Stray responses here are dropped; only the accept edge moves things on.
          if (instr_ready) begin
            pc_q    <= pc_q + 32'd4;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state   <= REQ;
`ifdef IF_ILLEGAL_CHECK_EN
            illegal_q <= 1'b0;
`endif
          end
        end
        default: begin
          state   <= REQ;
          valid_q <= 1'b0;
          req_q   <= 1'b1;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign func3  = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];
  assign func7  = instr_q[31:25];

`ifdef IF_ILLEGAL_CHECK_EN
  assign illegal_instr = illegal_q;
`else
  assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized scoreboard bench for instr_fetch
`timescale 1ns/1ps
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        illegal_instr;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rvalid;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [6:0]  w_opcode;
  logic [2:0]  w_func3;
  logic [6:0]  w_func7;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic        w_illegal;

  int checks;
  int failures;
  int accepts;
  bit stray_en;
  bit big_lat;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int          lat_tab  [9] = '{1, 1, 1, 1, 1, 5, 3, 2, 2};
  logic [31:0] data_tab [9] = '{32'h0010_0093, 32'h0000_A083, 32'h0020_8023, 32'h0041_71B3,
                                32'h0020_81B3, 32'h0020_81B3, 32'h0020_81B3,
                                32'h4000_70B3, 32'h0000_A083};

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .pc(pc),
    .opcode(opcode), .func3(func3), .func7(func7),
    .rd(rd), .rs1(rs1), .rs2(rs2),
    .illegal_instr(illegal_instr)
  );

  instr_fetch #(.RESET_PC(WRAP_PC)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(w_rvalid), .imem_rdata(NOP),
    .instr_valid(w_valid), .instr_ready(w_ready),
    .instr(w_instr), .pc(w_pc),
    .opcode(w_opcode), .func3(w_func3), .func7(w_func7),
    .rd(w_rd), .rs1(w_rs1), .rs2(w_rs2),
    .illegal_instr(w_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency memory for the wrap instance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_rvalid <= 1'b0;
    else        w_rvalid <= w_req;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode: supported = load, store, add/sub, or/and.
  function automatic logic model_illegal(input logic [31:0] w);
`ifdef IF_ILLEGAL_CHECK_EN
    int unsigned op, f3, f7;
    op = w % 128;
    f3 = (w / 4096) % 8;
    f7 = w / 33554432;
    if (op == 3 || op == 35) return 1'b0;
    if (op == 51 && f3 == 0 && (f7 == 0 || f7 == 32)) return 1'b0;
    if (op == 51 && (f3 == 6 || f3 == 7) && f7 == 0) return 1'b0;
    return 1'b1;
`else
    return (w != w);
`endif
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: return r;
      1: return (r & 32'hFFFF_FF80) | 32'h03;
      2: return {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, r[24:15], 3'b000, r[11:7], 7'h33};
      default: return {7'h00, r[24:15], ($urandom_range(0, 1) == 1) ? 3'b110 : 3'b111, r[11:7], 7'h33};
    endcase
  endfunction

  // Instruction memory model: random latency, pushes the expected fetch into the scoreboard.
  initial begin : mem_model
    int          lat_cnt;
    bit          busy;
    int          nreq;
    logic [31:0] resp;
    logic [31:0] exp_addr;
    busy = 0; lat_cnt = 0; nreq = 0; resp = '0; exp_addr = RESET_PC;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 0;
        imem_rvalid = 1'b0;
        exp_addr = RESET_PC;
        sb.delete();
      end else begin
        imem_rvalid = 1'b0;
        if (imem_req) chk("req_while_outstanding", {31'd0, busy}, 32'd0);
        if (busy) begin
          if (lat_cnt <= 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = resp;
            busy = 0;
          end else begin
            lat_cnt--;
          end
        end else if (imem_req) begin
          chk("req_addr", imem_addr, exp_addr);
          resp    = (nreq < 9) ? data_tab[nreq] : rand_word();
          lat_cnt = big_lat ? 6 : ((nreq < 9) ? lat_tab[nreq] : $urandom_range(1, 6));
          sb.push_back('{exp_addr, resp});
          exp_addr = exp_addr + 32'd4;
          nreq++;
          busy = 1;
        end else if (stray_en && instr_valid && $urandom_range(0, 3) == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = $urandom;
        end
      end
    end
  end

  // Monitor: compares the presented instruction against the scoreboard head, pops on accept.
  initial begin : monitor
    exp_t e;
    accepts = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && instr_valid) begin
        if (sb.size() == 0) begin
          chk("valid_without_request", 32'd1, 32'd0);
        end else begin
          e = sb[0];
          chk("instr", instr, e.data);
          chk("pc", pc, e.addr);
          chk("opcode", {25'd0, opcode}, e.data % 128);
          chk("rd", {27'd0, rd}, (e.data / 128) % 32);
          chk("func3", {29'd0, func3}, (e.data / 4096) % 8);
          chk("rs1", {27'd0, rs1}, (e.data / 32768) % 32);
          chk("rs2", {27'd0, rs2}, (e.data / 1048576) % 32);
          chk("func7", {25'd0, func7}, e.data / 33554432);
          chk("illegal_instr", {31'd0, illegal_instr}, {31'd0, model_illegal(e.data)});
          chk("req_during_hold", {31'd0, imem_req}, 32'd0);
          if (instr_ready) begin
            void'(sb.pop_front());
            accepts++;
          end
        end
      end
    end
  end

  initial begin : main
    logic [31:0] snap_instr, snap_pc;
    bit found;
    checks = 0; failures = 0;
    rst_n = 1'b0; instr_ready = 1'b0; w_ready = 1'b1;
    stray_en = 0; big_lat = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_illegal", {31'd0, illegal_instr}, 32'd0);
    chk("rst_wrap_addr", w_addr, WRAP_PC);

    @(posedge clk);
    #2 rst_n = 1'b1;

    // Latency-1 memory, always ready: requests at 0,3,6 and valid at 2,5,8.
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      instr_ready = 1'b1;
      #1;
      chk("req_cycle", {31'd0, imem_req}, {31'd0, (c == 0 || c == 3 || c == 6)});
      chk("valid_cycle", {31'd0, instr_valid}, {31'd0, (c == 2 || c == 5 || c == 8)});
      if (c == 0) chk("wrap_first_addr", w_addr, WRAP_PC);
      if (c == 3) begin
        chk("wrap_req", {31'd0, w_req}, 32'd1);
        chk("wrap_addr_after_accept", w_addr, 32'h0000_0000);
      end
    end

    // Back-pressure: hold ready low for 10 cycles while an instruction is valid.
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      instr_ready = 1'b0;
      #1;
      if (instr_valid) found = 1;
    end
    chk("bp_valid_seen", {31'd0, found}, 32'd1);
    snap_instr = instr;
    snap_pc    = pc;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      instr_ready = 1'b0;
      #1;
      chk("bp_valid", {31'd0, instr_valid}, 32'd1);
      chk("bp_instr", instr, snap_instr);
      chk("bp_pc", pc, snap_pc);
      chk("bp_no_req", {31'd0, imem_req}, 32'd0);
    end
    @(negedge clk);
    instr_ready = 1'b1;
    #1;
    @(negedge clk);
    instr_ready = 1'b0;
    #1;
    chk("bp_next_req", {31'd0, imem_req}, 32'd1);
    chk("bp_next_addr", imem_addr, snap_pc + 32'd4);

    // Random back-pressure, variable latency and stray responses during HOLD.
    stray_en = 1;
    repeat (400) begin
      @(negedge clk);
      instr_ready = ($urandom_range(0, 2) != 0);
    end
    stray_en = 0;

    // Reset while a long-latency fetch is in flight.
    big_lat = 1;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      instr_ready = 1'b1;
      #1;
      if (imem_req) found = 1;
    end
    chk("mid_req_seen", {31'd0, found}, 32'd1);
    @(negedge clk);
    #1;
    chk("mid_in_wait_req", {31'd0, imem_req}, 32'd0);
    chk("mid_in_wait_valid", {31'd0, instr_valid}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, imem_req}, 32'd1);
    chk("mid_rst_pc", pc, RESET_PC);
    chk("mid_rst_addr", imem_addr, RESET_PC);
    chk("mid_rst_instr", instr, NOP);
    chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("mid_rst_illegal", {31'd0, illegal_instr}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    big_lat = 0;
    @(negedge clk);
    #1;
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, RESET_PC);

    repeat (60) begin
      @(negedge clk);
      instr_ready = ($urandom_range(0, 3) != 0);
    end
    chk("progress", {31'd0, (accepts >= 30)}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the single-cycle RISC-V core, directly upstream of the control unit and register file. It holds the program counter and issues one request at a time to a variable-latency instruction memory. It captures the returned word into an instruction register and presents it, with pre-sliced opcode/func3/func7/register fields, through a valid/ready handshake. PC advances by 4 only when the core accepts the instruction. The core has no branches, so the block never redirects.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  one-cycle request pulse to instruction memory.
- imem_addr  out  32  fetch address; equals pc.
- imem_rvalid  in  1  instruction memory response valid (single-cycle pulse).
- imem_rdata  in  32  instruction word, sampled when imem_rvalid=1 in WAIT.
- instr_valid  out  1  instr register holds an unconsumed instruction.
- instr_ready  in  1  core accepts the instruction this cycle.
- instr  out  32  instruction register.
- pc  out  32  address of the instruction in instr, or of the fetch in flight.
- opcode  out  7  instr[6:0].
- func3  out  3  instr[14:12].
- func7  out  7  instr[31:25].
- rd, rs1, rs2  out  5 each  instr[11:7], instr[19:15], instr[24:20].
- illegal_instr  out  1  decoded-unsupported flag (see Configuration).

## Operation
- FSM states: REQ, WAIT, HOLD. Reset state is REQ.
- REQ: imem_req=1, imem_addr=pc. Go to WAIT unconditionally.
- WAIT: imem_req=0. If imem_rvalid=1, set instr<=imem_rdata, set instr_valid<=1, and go to HOLD. Otherwise stay in WAIT, with no timeout.
- HOLD: instr_valid=1, and instr and pc are stable. If instr_ready=1, set pc<=pc+4, set instr_valid<=0, and go to REQ. Otherwise stay in HOLD.
- imem_rvalid outside WAIT is ignored, with no state change and no capture.
- instr_ready while instr_valid=0 is ignored.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
- The field outputs are pure combinational slices of instr and are valid only while instr_valid=1.
- At most one request is outstanding. The instruction memory must return exactly one rvalid per imem_req.

## Timing
- Reset values, asynchronous on rst_n=0:
  - pc=RESET_PC
  - instr=32'h0000_0013 (NOP)
  - instr_valid=0
  - state=REQ, so imem_req=1 in the first cycle after reset release
  - illegal_instr=0
- Latency: imem_req in cycle N; earliest imem_rvalid in N+1; instr_valid high from N+2.
- Best-case throughput: one instruction per 3 cycles (REQ, WAIT with rvalid, HOLD with ready).
- Accept edge: the rising edge where instr_valid=1 and instr_ready=1. The next imem_req is in the following cycle with the new pc.
- Reset mid-operation: an in-flight request is abandoned. The instruction memory must share rst_n so no stale rvalid arrives afterwards.
- imem_rvalid in the same cycle as imem_req (zero-latency memory) is not supported and is ignored.

## Configuration
- Macro: IF_ILLEGAL_CHECK_EN.
- Defined: illegal_instr=instr_valid AND the instruction is not one of:
  - opcode 0000011 (load)
  - opcode 0100011 (store)
  - opcode 0110011 with (func3=000 and func7 in {0000000, 0100000}) or (func3 in {110, 111} and func7=0000000)
- Defined: the flag is registered alongside instr (computed from imem_rdata at capture), cleared on accept, and reset to 0. The flag is informational only; the handshake is unchanged.
- Not defined: illegal_instr is tied to 1'b0 and no check logic is synthesized.

## Test plan
- Reset with RESET_PC=0, memory latency 1, instr_ready=1 constantly:
  - imem_req at addresses 0, 4, 8 in cycles 0, 3, 6
  - instr_valid pulses in cycles 2, 5, 8
- Back-pressure: hold instr_ready=0 for 10 cycles after instr_valid. instr, pc and fields stay stable and no imem_req occurs. The first ready cycle advances pc by exactly 4.
- Variable latency (1, 5, 3 cycles) with data 32'h0020_81B3 (add x3,x1,x2):
  - opcode=0110011, rd=3, rs1=1, rs2=2, func3=000, func7=0000000
  - stray imem_rvalid during HOLD is ignored
- Wrap: RESET_PC=32'hFFFF_FFFC. After the first accept, imem_addr=32'h0000_0000.
- Assert rst_n=0 while in WAIT:
  - outputs return to reset values immediately
  - after release, imem_req occurs at RESET_PC
- With IF_ILLEGAL_CHECK_EN: 32'h4000_70B3 (func3=111, func7=0100000) gives illegal_instr=1, while 32'h0000_A083 (load) gives 0. Without the macro, illegal_instr stays 0 for both.
